serializer_tx: RTL and testbench

SERIALIZER_TX -- requirements
Module: serializer_tx

---
 rtl/ca1_pkg.sv | 14 +
 rtl/bit_counter.sv | 31 +++
 rtl/serializer_tx.sv | 102 ++++++++++
 tb/tb_serializer_tx.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ca1_pkg.sv
// Shared types and constants for the serial transmit path.
package ca1_pkg;

    // Transmitter control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } tx_state_t;

    // Default parallel word width.
    localparam int WORD_W = 10;

endpackage : ca1_pkg

// File: rtl/bit_counter.sv
// Bit counter with synchronous clear, count enable and a terminal-count flag.
// The count saturates at LAST: enable is ignored once the flag is high,
// so the counter never wraps.
module bit_counter #(
    parameter int CW   = 4,
    parameter int LAST = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CW-1:0] LAST_VAL = CW'(LAST);

    logic [CW-1:0] count;

    // Count register: reset and clear win over enable; hold at terminal count.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + CW'(1);
        end
    end

    // Terminal-count flag, unsigned compare at the counter width.
    assign tc = (count == LAST_VAL);

endmodule : bit_counter

// File: rtl/serializer_tx.sv
// Parallel-to-serial transmitter, MSB first, feeding a shift-left receiver.
//
// Handshake: serout carries a bit whenever sout_valid is high; the bit is
// consumed on a rising edge where sout_valid and sready are both high.
// While sready is low, serout and sout_valid hold indefinitely. sout_valid
// never depends on sready, and no output depends combinationally on inputs.
module serializer_tx
    import ca1_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pin,
    input  logic             sready,
    output logic             serout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    tx_state_t        state;
    tx_state_t        state_next;
    logic [WIDTH-1:0] sr;
    logic             load;
    logic             shift_en;
    logic             cnt_tc;

    // State register; reset aborts any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode from registered state and shift register.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        serout     = 1'b0;
        sout_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                sout_valid = 1'b1;
                busy       = 1'b1;
                serout     = sr[WIDTH-1];
                if (sready) begin
                    shift_en = 1'b1;
                    if (cnt_tc) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Shift register: capture the word on load, move left on each accepted bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= pin;
        end else if (shift_en) begin
            sr <= {sr[WIDTH-2:0], 1'b0};
        end
    end

    // Counts accepted bits; terminal count marks the last bit of the word.
    bit_counter #(
        .CW   (CW),
        .LAST (WIDTH - 1)
    ) u_bit_counter (
        .clk (clk),
        .rst (rst),
        .clr (load),
        .en  (shift_en),
        .tc  (cnt_tc)
    );

endmodule : serializer_tx

// File: tb/tb_serializer_tx.sv
// Directed bench for serializer_tx with a loopback shift-left receiver model.
module tb_serializer_tx;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] pin;
    logic       sready;
    logic       serout;
    logic       sout_valid;
    logic       busy;
    logic       done;

    logic [9:0]  rx;
    logic [15:0] exp_q[$];
    int          checks;
    int          errors;

    serializer_tx #(.WIDTH(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pin        (pin),
        .sready     (sready),
        .serout     (serout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream 10-bit shift-left receiver.
    always @(posedge clk) begin
        if (rst) begin
            rx <= '0;
        end else if (sout_valid && sready) begin
            rx <= {rx[8:0], serout};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_serout"}, 32'(serout), 32'd0);
        check({tag, "_valid"},  32'(sout_valid), 32'd0);
        check({tag, "_busy"},   32'(busy), 32'd0);
        check({tag, "_done"},   32'(done), 32'd0);
    endtask

    // Sends one word. Bits are checked against exp_q (hand-filled by the caller).
    // sready is low in cycles stall_lo..stall_hi after the load edge; a second
    // start with 10'h3FF is offered in cycle restart_cyc; done is due in done_cyc.
    task automatic xmit(input string tag, input logic [9:0] word, input int stall_lo,
                        input int stall_hi, input int restart_cyc, input int done_cyc);
        pin    = word;
        start  = 1'b1;
        sready = 1'b1;
        tick();
        start = 1'b0;
        pin   = 10'h155;
        for (int c = 1; c < done_cyc; c++) begin
            sready = !(c >= stall_lo && c <= stall_hi);
            if (c == restart_cyc) begin
                start = 1'b1;
                pin   = 10'h3FF;
            end else begin
                start = 1'b0;
            end
            check({tag, "_valid"}, 32'(sout_valid), 32'd1);
            check({tag, "_busy"},  32'(busy), 32'd1);
            check({tag, "_done_early"}, 32'(done), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s_extra_bit: observed bit in cycle %0d expected none", tag, c);
            end else begin
                check({tag, "_serout"}, 32'(serout), 32'(exp_q[0]));
                if (sready) begin
                    void'(exp_q.pop_front());
                end
            end
            tick();
        end
        sready = 1'b1;
        start  = 1'b0;
        check({tag, "_done"},       32'(done), 32'd1);
        check({tag, "_done_busy"},  32'(busy), 32'd1);
        check({tag, "_done_valid"}, 32'(sout_valid), 32'd0);
        check({tag, "_done_serout"}, 32'(serout), 32'd0);
        check({tag, "_bits_left"},  32'(exp_q.size()), 32'd0);
        check({tag, "_rx"},         32'(rx), 32'(word));
        exp_q.delete();
        tick();
        check_idle({tag, "_after"});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        pin    = '0;
        sready = 1'b0;

        // Reset held two cycles, then idle with start low.
        tick();
        check_idle("rst1");
        tick();
        check_idle("rst2");
        rst = 1'b0;
        sready = 1'b1;
        tick();
        check_idle("idle1");
        tick();
        check_idle("idle2");

        // Plain transfer: bits in k+1..k+10, done in k+11.
        exp_q = '{16'd1, 16'd0, 16'd1, 16'd1, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd0};
        xmit("plain", 10'b1011001110, 0, -1, 0, 11);

        // Three stall cycles in k+3..k+5: done moves to k+14.
        exp_q = '{16'd1, 16'd0, 16'd1, 16'd1, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd0};
        xmit("stall", 10'b1011001110, 3, 5, 0, 14);

        // Loopback word into the receiver.
        exp_q = '{16'd1, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd0, 16'd1, 16'd0, 16'd1};
        xmit("loop", 10'h2A5, 0, -1, 0, 11);

        // Second start in k+4 with 10'h3FF is ignored.
        exp_q = '{16'd1, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd0, 16'd1, 16'd0, 16'd1};
        xmit("restart", 10'h2A5, 0, -1, 4, 11);

        // Reset in cycle k+6 aborts the word with no done pulse.
        pin    = 10'h2A5;
        start  = 1'b1;
        sready = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            check("abort_valid", 32'(sout_valid), 32'd1);
            if (c == 6) begin
                rst = 1'b1;
            end
            tick();
        end
        check_idle("abort_rst");
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_idle("abort_quiet");
        end

        // Fresh word after the abort.
        exp_q = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1};
        xmit("post_abort", 10'h001, 0, -1, 0, 11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_serializer_tx
